pwm_dc: RTL and testbench



---
 rtl/pwm_dc_if.sv | 18 +
 rtl/pwm_dc.sv | 91 +++++++++
 tb/tb_pwm_dc.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_dc_if.sv
// Tile I/O bundle for pwm_dc: the 8-bit pad-side input and output buses.
`timescale 1ns/1ps
interface pwm_dc_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  // Pad side drives io_in and observes io_out.
  modport master (
    output io_in,
    input  io_out
  );

  // The PWM block reads io_in and drives io_out.
  modport slave (
    input  io_in,
    output io_out
  );
endinterface

// File: rtl/pwm_dc.sv
// Button-controlled PWM: 10-clock period, duty 0..10 adjusted in single steps by two
// asynchronous push-buttons. Buttons are synchronised through a 3-flop chain and
// edge-detected; duty changes take effect only at the period boundary.
`timescale 1ns/1ps
module pwm_dc (
  input logic     clk,
  input logic     rst,
  pwm_dc_if.slave bus
);

  localparam logic [3:0] PeriodLast = 4'd9;
  localparam logic [3:0] DutyMax    = 4'd10;
  localparam logic [3:0] DutyReset  = 4'd5;

  // io_in[5:4] are the clock/reset pads, already routed to clk/rst; io_in[3:0] are unused.
  logic unused_io_in;
  assign unused_io_in = ^bus.io_in[5:0];

  logic       inc_btn;
  logic       dec_btn;
  assign inc_btn = bus.io_in[6];
  assign dec_btn = bus.io_in[7];

  // Synchroniser chains: bit 0 = s1, bit 1 = s2, bit 2 = s3.
  logic [2:0] inc_sync_q;
  logic [2:0] dec_sync_q;
  logic       inc_press;
  logic       dec_press;

  logic [3:0] duty_q, duty_d;
  logic [3:0] duty_act_q, duty_act_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pwm_q, pwm_d;

  // Shift both button inputs through their synchroniser chains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_sync_q <= 3'b000;
      dec_sync_q <= 3'b000;
    end else begin
      inc_sync_q <= {inc_sync_q[1:0], inc_btn};
      dec_sync_q <= {dec_sync_q[1:0], dec_btn};
    end
  end

  // One-cycle press pulse on each synchronised rising edge; holding gives a single step.
  assign inc_press = inc_sync_q[1] & ~inc_sync_q[2];
  assign dec_press = dec_sync_q[1] & ~dec_sync_q[2];

  // Saturating target-duty update; simultaneous presses cancel.
  always_comb begin
    duty_d = duty_q;
    unique case ({inc_press, dec_press})
      2'b10: begin
        if (duty_q < DutyMax) duty_d = duty_q + 4'd1;
      end
      2'b01: begin
        if (duty_q != 4'd0) duty_d = duty_q - 4'd1;
      end
      default: begin
        duty_d = duty_q;
      end
    endcase
  end

  // Period counter, active-duty reload at the boundary, and next PWM level.
  always_comb begin
    // Any illegal count (10..15) recovers to 0 on the next edge.
    cnt_d      = (cnt_q >= PeriodLast) ? 4'd0 : cnt_q + 4'd1;
    duty_act_d = (cnt_q == PeriodLast) ? duty_q : duty_act_q;
    pwm_d      = (cnt_q < duty_act_q);
  end

  // Duty, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q     <= DutyReset;
      duty_act_q <= DutyReset;
      cnt_q      <= 4'd0;
      pwm_q      <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign bus.io_out = {1'b0, duty_q, pwm_q, 2'b00};

endmodule

// File: tb/tb_pwm_dc.sv
// Self-checking bench for pwm_dc: a cycle model pushes the expected io_out into a
// scoreboard at each rising edge, popped and compared on the falling edge, plus
// directed checks of duty values and per-period PWM patterns.
`timescale 1ns/1ps
module tb_pwm_dc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inc = 1'b0;
  logic dec = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  // Bench-side model state.
  logic [2:0] m_is, m_ds;
  logic [3:0] m_duty, m_act, m_cnt;
  logic       m_pwm;

  pwm_dc_if bus ();
  assign bus.io_in = {dec, inc, clk, rst, 4'b0000};

  pwm_dc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
    n_cmp++;
    assert (obs === req)
    else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_is   = 3'b000;
    m_ds   = 3'b000;
    m_duty = 4'd5;
    m_act  = 4'd5;
    m_cnt  = 4'd0;
    m_pwm  = 1'b0;
    exp_q.delete();
  endtask

  // One clock: update the model at the rising edge, compare on the falling edge.
  task automatic step();
    logic ip, dp;
    logic [7:0] e;
    @(posedge clk);
    ip    = m_is[1] & ~m_is[2];
    dp    = m_ds[1] & ~m_ds[2];
    m_pwm = (m_cnt < m_act);
    if (m_cnt == 4'd9) m_act = m_duty;
    m_cnt = (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
    if (ip && !dp && m_duty < 4'd10) m_duty = m_duty + 4'd1;
    else if (dp && !ip && m_duty > 4'd0) m_duty = m_duty - 4'd1;
    m_is = {m_is[1:0], inc};
    m_ds = {m_ds[1:0], dec};
    exp_q.push_back({1'b0, m_duty, m_pwm, 2'b00});
    @(negedge clk);
    e = exp_q.pop_front();
    check("cycle", bus.io_out, e);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // 2 clocks high, 2 clocks low on the selected buttons.
  task automatic pulse(input logic i, input logic d);
    inc = i;
    dec = d;
    steps(2);
    inc = 1'b0;
    dec = 1'b0;
    steps(2);
  endtask

  task automatic check_duty(input logic [3:0] d);
    check("duty", {4'b0000, bus.io_out[6:3]}, {4'b0000, d});
  endtask

  // Align to a period start, then check d high cycles followed by 10-d low.
  task automatic period_check(input int d);
    int guard = 0;
    while (m_cnt != 4'd0 && guard < 12) begin
      step();
      guard++;
    end
    if (m_cnt != 4'd0) begin
      n_cmp++;
      n_err++;
      $error("FAIL align: observed cnt %0d required 0", m_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      check("period", {7'b0, bus.io_out[2]}, {7'b0, (i < d)});
    end
  endtask

  // Asynchronous 1 ns reset pulse, taken just after a falling edge.
  task automatic async_reset();
    #1;
    rst = 1'b1;
    model_reset();
    #0.5;
    check("async_reset", bus.io_out, 8'h28);
    #0.5;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", bus.io_out, 8'h28);
    rst = 1'b0;

    // Idle: 5 high / 5 low from edge 1, duty 5.
    for (int i = 0; i < 30; i++) begin
      step();
      check("idle_pwm", {7'b0, bus.io_out[2]}, {7'b0, ((i % 10) < 5)});
    end
    check_duty(4'd5);

    // Three inc pulses -> duty 8.
    repeat (3) pulse(1'b1, 1'b0);
    check_duty(4'd8);
    steps(10);
    period_check(8);

    // Asynchronous reset mid-period while output is high.
    while (m_cnt != 4'd3) step();
    check("pre_reset_pwm", {7'b0, bus.io_out[2]}, 8'd1);
    async_reset();
    check_duty(4'd5);
    period_check(5);

    // Twelve inc pulses from reset saturate at 10, then one dec gives 9.
    async_reset();
    repeat (12) pulse(1'b1, 1'b0);
    check_duty(4'd10);
    steps(10);
    period_check(10);
    period_check(10);
    pulse(1'b0, 1'b1);
    check_duty(4'd9);
    steps(10);
    period_check(9);

    // Dec held for 50 clocks is a single step.
    async_reset();
    dec = 1'b1;
    steps(50);
    check_duty(4'd4);
    dec = 1'b0;
    steps(2);
    check_duty(4'd4);
    repeat (7) pulse(1'b0, 1'b1);
    check_duty(4'd0);
    steps(10);
    period_check(0);
    pulse(1'b0, 1'b1);
    check_duty(4'd0);

    // Simultaneous inc and dec leave duty unchanged.
    async_reset();
    pulse(1'b1, 1'b1);
    check_duty(4'd5);
    steps(10);
    period_check(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
